// File: rtl/cic_interp_param.sv
// CIC interpolator: N comb stages, zero-stuffing expander by R, N integrators.
// Optional CIC_INTERP_GAIN_NORM_EN: rounded right shift of the output for unity DC gain.
module cic_interp_param #(
   parameter int WIN = 16,
   parameter int N   = 3,
   parameter int R   = 4,
   parameter int WG  = 22
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic signed [WIN-1:0]       i_data,
   input  logic                        i_valid,
   output logic                        o_ready,
   output logic signed [WIN+WG-1:0]    o_data,
   output logic                        o_valid
);

   localparam int W  = WIN + WG;
   localparam int KW = $clog2(R);

   // Bits of growth of the full filter: ceil(log2(R^N)).
   function automatic int growth_bits(input int n, input int r);
      longint p;
      int     b;
      p = 1;
      for (int i = 0; i < n; i++) p = p * longint'(r);
      b = 0;
      while ((longint'(1) << b) < p) b++;
      return b;
   endfunction

   generate
      if (WIN < 1) begin : g_bad_win
         $error("cic_interp_param: WIN must be at least 1");
      end
      if (N < 1 || N > 6) begin : g_bad_n
         $error("cic_interp_param: N must be in 1..6");
      end
      if (R < 2 || R > 64) begin : g_bad_r
         $error("cic_interp_param: R must be in 2..64");
      end
      if (WG < growth_bits(N, R)) begin : g_bad_wg
         $error("cic_interp_param: WG too small for N and R");
      end
`ifdef CIC_INTERP_GAIN_NORM_EN
      if ((R & (R - 1)) != 0) begin : g_bad_pow2
         $error("cic_interp_param: R must be a power of two with gain normalisation");
      end
`endif
   endgenerate

   logic signed [W-1:0]  comb_in [0:N];
   logic signed [W-1:0]  dly [0:N-1];
   logic signed [W-1:0]  comb_q;
   logic                 busy;
   logic [KW-1:0]        k;
   logic signed [W-1:0]  exp_data;
   logic                 vld [0:N];
   logic signed [W-1:0]  integ [0:N-1];
   logic signed [W-1:0]  integ_in [0:N-1];
   logic signed [W-1:0]  out_val;
   logic                 accept;

   assign o_ready = ~busy | (k == KW'(R - 1));
   assign accept  = i_valid & o_ready;

   always_comb begin
      comb_in[0] = {{WG{i_data[WIN-1]}}, i_data};
      for (int i = 0; i < N; i++) comb_in[i+1] = comb_in[i] - dly[i];
   end

   always_comb begin
      integ_in[0] = exp_data;
      for (int i = 1; i < N; i++) integ_in[i] = integ[i-1];
   end

`ifdef CIC_INTERP_GAIN_NORM_EN
   localparam int SH = (N - 1) * $clog2(R);
   generate
      if (SH == 0) begin : g_norm_none
         assign out_val = integ[N-1];
      end else begin : g_norm
         localparam logic signed [W-1:0] RND = W'(longint'(1) << (SH - 1));
         logic signed [W-1:0] biased;
         assign biased  = integ[N-1] + RND;
         assign out_val = biased >>> SH;
      end
   endgenerate
`else
   assign out_val = integ[N-1];
`endif

   // vld[0] tags the expander slot register; vld[i] tags the input of integrator i.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            dly[i]   <= '0;
            integ[i] <= '0;
         end
         for (int i = 0; i <= N; i++) vld[i] <= 1'b0;
         comb_q   <= '0;
         busy     <= 1'b0;
         k        <= '0;
         exp_data <= '0;
         o_data   <= '0;
         o_valid  <= 1'b0;
      end else begin
         if (accept) begin
            for (int i = 0; i < N; i++) dly[i] <= comb_in[i];
            comb_q <= comb_in[N];
         end

         vld[0] <= busy;
         if (busy) exp_data <= (k == '0) ? comb_q : '0;

         if (accept) begin
            busy <= 1'b1;
            k    <= '0;
         end else if (busy) begin
            if (k == KW'(R - 1)) begin
               busy <= 1'b0;
               k    <= '0;
            end else begin
               k <= k + KW'(1);
            end
         end

         for (int i = 0; i < N; i++) begin
            vld[i+1] <= vld[i];
            if (vld[i]) integ[i] <= integ[i] + integ_in[i];
         end

         o_valid <= vld[N];
         if (vld[N]) o_data <= out_val;
      end
   end

endmodule

// File: tb/tb_cic_interp_param.sv
// Directed bench for cic_interp_param at default parameters, either build of CIC_INTERP_GAIN_NORM_EN.
module tb_cic_interp_param;
   localparam int WIN = 16;
   localparam int N   = 3;
   localparam int R   = 4;
   localparam int WG  = 22;
   localparam int W   = WIN + WG;

   logic                  clk = 1'b0;
   logic                  rst;
   logic signed [WIN-1:0] i_data;
   logic                  i_valid;
   logic                  o_ready;
   logic signed [W-1:0]   o_data;
   logic                  o_valid;

   cic_interp_param #(.WIN(WIN), .N(N), .R(R), .WG(WG)) dut (
      .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
      .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic longint norm(input longint v);
`ifdef CIC_INTERP_GAIN_NORM_EN
      return (v + 64'sd8) >>> 4;
`else
      return v;
`endif
   endfunction

   typedef struct {
      string  name;
      int     first;
      int     rest;
      int     idx;
      longint exp;
   } vec_t;

   vec_t   vecs[$];
   longint outq[$];
   longint sq[$];
   int     lat, bad_period, gaps;

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      @(posedge clk); #1 rst = 1'b1;
   endtask

   // i_valid held high; first accepted sample is 'first', all later ones 'rest'.
   task automatic run_stream(input int first, input int rest, input int ncyc);
      int first_acc, first_out, last_acc;
      bit acc;
      outq.delete();
      bad_period = 0; gaps = 0;
      first_acc = -1; first_out = -1; last_acc = -1;
      i_data  = WIN'(first);
      i_valid = 1'b1;
      repeat (ncyc) begin
         @(negedge clk);
         if (o_valid) begin
            outq.push_back(longint'(o_data));
            if (first_out < 0) first_out = cyc;
         end else if (first_out >= 0) begin
            gaps++;
         end
         acc = o_ready && i_valid;
         if (acc) begin
            if (first_acc < 0) first_acc = cyc + 1;
            if (last_acc >= 0 && (cyc + 1 - last_acc) != R) bad_period++;
            last_acc = cyc + 1;
         end
         @(posedge clk); #1;
         if (acc) i_data = WIN'(rest);
      end
      i_valid = 1'b0;
      lat = (first_out < 0 || first_acc < 0) ? -1 : first_out - first_acc;
      repeat (20) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int     imp[12];
      int     cur_first, cur_rest, vc, held_bad, nvalid;
      bit     have;
      longint got;

      imp = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0, 0};
      for (int i = 0; i < 12; i++) vecs.push_back('{"impulse", 1, 0, i, norm(longint'(imp[i]))});
      vecs.push_back('{"dc", 1, 1, 4,  norm(13)});
      vecs.push_back('{"dc", 1, 1, 5,  norm(15)});
      vecs.push_back('{"dc", 1, 1, 6,  norm(16)});
      vecs.push_back('{"dc", 1, 1, 20, norm(16)});
      vecs.push_back('{"dc", 1, 1, 30, norm(16)});
      vecs.push_back('{"fullscale", -32768, -32768, 0,  norm(-32768)});
      vecs.push_back('{"fullscale", -32768, -32768, 5,  norm(-491520)});
      vecs.push_back('{"fullscale", -32768, -32768, 30, norm(-524288)});

      rst = 1'b0; i_valid = 1'b0; i_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_o_valid", longint'(o_valid), 0);
      check("reset_o_data",  longint'(o_data),  0);
      check("reset_o_ready", longint'(o_ready), 1);
      @(posedge clk); #2 rst = 1'b1;
      @(negedge clk);
      check("post_reset_o_ready", longint'(o_ready), 1);

      have = 1'b0; cur_first = 0; cur_rest = 0;
      foreach (vecs[i]) begin
         if (!have || vecs[i].first != cur_first || vecs[i].rest != cur_rest) begin
            do_reset();
            run_stream(vecs[i].first, vecs[i].rest, 45);
            cur_first = vecs[i].first;
            cur_rest  = vecs[i].rest;
            have      = 1'b1;
            check({vecs[i].name, "_latency"},   longint'(lat),        N + 2);
            check({vecs[i].name, "_accept_period"}, longint'(bad_period), 0);
            check({vecs[i].name, "_valid_gaps"}, longint'(gaps),      0);
         end
         got = (vecs[i].idx < outq.size()) ? outq[vecs[i].idx] : 64'sh7fffffff;
         check($sformatf("%s[%0d]", vecs[i].name, vecs[i].idx), got, vecs[i].exp);
      end

      // Sparse accepts of 1, ten cycles apart: four valid slots each, hold in gaps.
      do_reset();
      sq.delete();
      held_bad = 0;
      for (int a = 0; a < 3; a++) begin
         vc = 0;
         i_data  = WIN'(1);
         i_valid = 1'b1;
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_valid) begin
               vc++;
               sq.push_back(longint'(o_data));
            end else if (sq.size() > 0 && longint'(o_data) != sq[$]) begin
               held_bad++;
            end
            @(posedge clk); #1 i_valid = 1'b0;
         end
         check($sformatf("sparse_valid_count[%0d]", a), longint'(vc), 4);
      end
      check("sparse_hold", longint'(held_bad), 0);
      check("sparse_out[4]",  (sq.size() > 4)  ? sq[4]  : 64'sh7fffffff, norm(13));
      check("sparse_out[11]", (sq.size() > 11) ? sq[11] : 64'sh7fffffff, norm(16));

      // Reset at slot k=1 of a burst; o_data still holds the sparse result here.
      i_data  = WIN'(100);
      i_valid = 1'b1;
      @(posedge clk); #1 i_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      #1;
      check("midreset_o_valid", longint'(o_valid), 0);
      check("midreset_o_data",  longint'(o_data),  0);
      check("midreset_o_ready", longint'(o_ready), 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("release_o_ready", longint'(o_ready), 1);
      nvalid = 0;
      repeat (15) begin
         @(negedge clk);
         if (o_valid) nvalid++;
      end
      check("no_residual_output", longint'(nvalid), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
